// File: rtl/cw_winnow_if.sv
// Handshake bundle between the winnowing filter and its surroundings: session
// control, the tag-cache load port, the packet input, the wheat output and status.
interface cw_winnow_if #(
   parameter int CTRSIZE  = 16,
   parameter int TAGSIZE  = 16,
   parameter int DATASIZE = 32
);
   logic                start;
   logic                load_valid;
   logic [TAGSIZE-1:0]  load_tag;
   logic                load_ready;
   logic                in_valid;
   logic                in_ready;
   logic [CTRSIZE-1:0]  in_ctr;
   logic [DATASIZE-1:0] in_data;
   logic [TAGSIZE-1:0]  in_tag;
   logic                out_valid;
   logic                out_ready;
   logic [CTRSIZE-1:0]  out_ctr;
   logic [DATASIZE-1:0] out_data;
   logic [CTRSIZE-1:0]  wheat_cnt;
   logic [CTRSIZE-1:0]  chaff_cnt;
   logic                busy;

   modport master (
      output start, load_valid, load_tag, in_valid, in_ctr, in_data, in_tag, out_ready,
      input  load_ready, in_ready, out_valid, out_ctr, out_data, wheat_cnt, chaff_cnt, busy
   );

   modport slave (
      input  start, load_valid, load_tag, in_valid, in_ctr, in_data, in_tag, out_ready,
      output load_ready, in_ready, out_valid, out_ctr, out_data, wheat_cnt, chaff_cnt, busy
   );
endinterface

// File: rtl/cw_winnow.sv
// Winnowing receiver: loads a per-counter MAC tag cache, then forwards packets whose
// tag matches an unconsumed cache entry (wheat) and drops/counts everything else (chaff).
module cw_winnow #(
   parameter int CTRSIZE   = 16,
   parameter int TAGSIZE   = 16,
   parameter int CACHESIZE = 64,
   parameter int DATASIZE  = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   cw_winnow_if.slave    bus
);
   localparam int IDXW = (CACHESIZE > 1) ? $clog2(CACHESIZE) : 1;
   localparam logic [CTRSIZE:0]   WINDOW   = (CTRSIZE+1)'(CACHESIZE);
   localparam logic [IDXW-1:0]    LAST_IDX = IDXW'(CACHESIZE - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t                state_reg;
   logic [IDXW-1:0]       idx_reg;
   logic [CACHESIZE-1:0]  used_reg;
   logic                  out_valid_reg;
   logic [CTRSIZE-1:0]    out_ctr_reg;
   logic [DATASIZE-1:0]   out_data_reg;
   logic [CTRSIZE-1:0]    wheat_cnt_reg;
   logic [CTRSIZE-1:0]    chaff_cnt_reg;

   logic [TAGSIZE-1:0]    cache_mem [CACHESIZE];

   logic [IDXW-1:0]       pkt_idx;
   logic [CACHESIZE-1:0]  set_mask;
   logic [CACHESIZE-1:0]  used_next;
   logic                  in_window;
   logic                  is_wheat;
   logic                  in_ready_int;
   logic                  accept;

   assign pkt_idx = bus.in_ctr[IDXW-1:0];

   generate
      for (genvar gi = 0; gi < CACHESIZE; gi++) begin : g_mask
         assign set_mask[gi] = (pkt_idx == IDXW'(gi));
      end
   endgenerate

   // Tag lookup is asynchronous so classification completes in the accept cycle.
   always_comb begin
      in_window = ({1'b0, bus.in_ctr} < WINDOW);
      is_wheat  = in_window && (bus.in_tag == cache_mem[pkt_idx]) && !used_reg[pkt_idx];
      used_next = used_reg | set_mask;
   end

   assign in_ready_int = (state_reg == RUN) && (!out_valid_reg || bus.out_ready);
   assign accept       = bus.in_valid && in_ready_int && !bus.start;

   always_ff @(posedge clk) begin
      if (state_reg == LOAD && bus.load_valid && !bus.start)
         cache_mem[idx_reg] <= bus.load_tag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         used_reg      <= '0;
         out_valid_reg <= 1'b0;
         out_ctr_reg   <= '0;
         out_data_reg  <= '0;
         wheat_cnt_reg <= '0;
         chaff_cnt_reg <= '0;
      end else if (bus.start) begin
         state_reg     <= LOAD;
         idx_reg       <= '0;
         used_reg      <= '0;
         out_valid_reg <= 1'b0;
         wheat_cnt_reg <= '0;
         chaff_cnt_reg <= '0;
      end else begin
         // Drain first; a wheat load below overrides this in the same cycle.
         if (out_valid_reg && bus.out_ready)
            out_valid_reg <= 1'b0;
         case (state_reg)
            LOAD: begin
               if (bus.load_valid) begin
                  idx_reg <= idx_reg + 1'b1;
                  if (idx_reg == LAST_IDX)
                     state_reg <= RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  if (is_wheat) begin
                     out_valid_reg <= 1'b1;
                     out_ctr_reg   <= bus.in_ctr;
                     out_data_reg  <= bus.in_data;
                     used_reg      <= used_next;
                     if (wheat_cnt_reg != '1)
                        wheat_cnt_reg <= wheat_cnt_reg + 1'b1;
                     if (&used_next)
                        state_reg <= IDLE;
                  end else if (chaff_cnt_reg != '1) begin
                     chaff_cnt_reg <= chaff_cnt_reg + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.load_ready = (state_reg == LOAD);
   assign bus.in_ready   = in_ready_int;
   assign bus.busy       = (state_reg != IDLE);
   assign bus.out_valid  = out_valid_reg;
   assign bus.out_ctr    = out_ctr_reg;
   assign bus.out_data   = out_data_reg;
   assign bus.wheat_cnt  = wheat_cnt_reg;
   assign bus.chaff_cnt  = chaff_cnt_reg;
endmodule

// File: tb/tb_cw_winnow.sv
// Directed bench for cw_winnow with a 4-entry tag cache; each check is an immediate assertion.
module tb_cw_winnow;
   localparam int CTRSIZE   = 16;
   localparam int TAGSIZE   = 16;
   localparam int CACHESIZE = 4;
   localparam int DATASIZE  = 32;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   cw_winnow_if #(.CTRSIZE(CTRSIZE), .TAGSIZE(TAGSIZE), .DATASIZE(DATASIZE)) bus_if ();

   cw_winnow #(
      .CTRSIZE(CTRSIZE), .TAGSIZE(TAGSIZE), .CACHESIZE(CACHESIZE), .DATASIZE(DATASIZE)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pkt(input logic v, input logic [15:0] ctr, input logic [15:0] tag,
                      input logic [31:0] data);
      bus_if.in_valid = v;
      bus_if.in_ctr   = ctr;
      bus_if.in_tag   = tag;
      bus_if.in_data  = data;
   endtask

   task automatic load(input logic v, input logic [15:0] tag);
      bus_if.load_valid = v;
      bus_if.load_tag   = tag;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus_if.start     = 1'b0;
      bus_if.out_ready = 1'b0;
      load(1'b0, 16'h0);
      pkt(1'b0, 16'h0, 16'h0, 32'h0);
      tick();
      tick();
      chk("rst_load_ready", 32'(bus_if.load_ready), 32'd0);
      chk("rst_in_ready",   32'(bus_if.in_ready),   32'd0);
      chk("rst_out_valid",  32'(bus_if.out_valid),  32'd0);
      chk("rst_busy",       32'(bus_if.busy),       32'd0);
      chk("rst_out_ctr",    32'(bus_if.out_ctr),    32'd0);
      chk("rst_out_data",   bus_if.out_data,        32'd0);
      chk("rst_wheat",      32'(bus_if.wheat_cnt),  32'd0);
      chk("rst_chaff",      32'(bus_if.chaff_cnt),  32'd0);
      rst_n = 1'b1;
      tick();

      // 1: start, load A0,B1,C2,D3 with gaps; a packet offered during LOAD is ignored
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      chk("t1_load_ready", 32'(bus_if.load_ready), 32'd1);
      chk("t1_busy",       32'(bus_if.busy),       32'd1);
      chk("t1_in_ready",   32'(bus_if.in_ready),   32'd0);
      load(1'b1, 16'h00A0); tick();
      load(1'b0, 16'h0);    pkt(1'b1, 16'd0, 16'h00A0, 32'h55); tick();
      pkt(1'b0, 16'd0, 16'h0, 32'h0);
      load(1'b1, 16'h00B1); tick();
      load(1'b1, 16'h00C2); tick();
      load(1'b0, 16'h0);    tick();
      chk("t1_still_load", 32'(bus_if.load_ready), 32'd1);
      load(1'b1, 16'h00D3); tick();
      load(1'b0, 16'h0);
      chk("t1_load_done",  32'(bus_if.load_ready), 32'd0);
      chk("t1_run_busy",   32'(bus_if.busy),       32'd1);
      chk("t1_run_ready",  32'(bus_if.in_ready),   32'd1);
      chk("t1_no_chaff",   32'(bus_if.chaff_cnt),  32'd0);

      // 2: (0,A0) wheat, (1,FFFF) chaff, (2,C2) wheat, out_ready=1
      bus_if.out_ready = 1'b1;
      pkt(1'b1, 16'd0, 16'h00A0, 32'h100); tick();
      chk("t2_ov0",   32'(bus_if.out_valid), 32'd1);
      chk("t2_ctr0",  32'(bus_if.out_ctr),   32'd0);
      chk("t2_data0", bus_if.out_data,       32'h100);
      pkt(1'b1, 16'd1, 16'hFFFF, 32'h101); tick();
      chk("t2_ov1",   32'(bus_if.out_valid), 32'd0);
      chk("t2_chaff1", 32'(bus_if.chaff_cnt), 32'd1);
      pkt(1'b1, 16'd2, 16'h00C2, 32'h102); tick();
      chk("t2_ov2",   32'(bus_if.out_valid), 32'd1);
      chk("t2_ctr2",  32'(bus_if.out_ctr),   32'd2);
      chk("t2_data2", bus_if.out_data,       32'h102);
      pkt(1'b0, 16'd0, 16'h0, 32'h0); tick();
      chk("t2_drain", 32'(bus_if.out_valid), 32'd0);
      chk("t2_wheat", 32'(bus_if.wheat_cnt), 32'd2);
      chk("t2_chaff", 32'(bus_if.chaff_cnt), 32'd1);

      // 3: replay (0,A0), out-of-window (7,A0) and (5,B1)
      pkt(1'b1, 16'd0, 16'h00A0, 32'h200); tick();
      chk("t3_replay_ov", 32'(bus_if.out_valid), 32'd0);
      pkt(1'b1, 16'd7, 16'h00A0, 32'h201); tick();
      chk("t3_win7_ov",   32'(bus_if.out_valid), 32'd0);
      pkt(1'b1, 16'd5, 16'h00B1, 32'h202); tick();
      chk("t3_win5_ov",   32'(bus_if.out_valid), 32'd0);
      chk("t3_chaff",     32'(bus_if.chaff_cnt), 32'd4);
      chk("t3_wheat",     32'(bus_if.wheat_cnt), 32'd2);

      // 4: backpressure with (1,B1) pending, (3,D3) offered
      bus_if.out_ready = 1'b0;
      pkt(1'b1, 16'd1, 16'h00B1, 32'h301); tick();
      chk("t4_ov",    32'(bus_if.out_valid), 32'd1);
      chk("t4_ctr1",  32'(bus_if.out_ctr),   32'd1);
      pkt(1'b1, 16'd3, 16'h00D3, 32'h303);
      chk("t4_stall_rdy", 32'(bus_if.in_ready), 32'd0);
      tick();
      tick();
      chk("t4_hold_ov",   32'(bus_if.out_valid), 32'd1);
      chk("t4_hold_ctr",  32'(bus_if.out_ctr),   32'd1);
      chk("t4_hold_data", bus_if.out_data,       32'h301);
      chk("t4_hold_wheat", 32'(bus_if.wheat_cnt), 32'd3);
      bus_if.out_ready = 1'b1;
      #1;
      chk("t4_release_rdy", 32'(bus_if.in_ready), 32'd1);
      tick();
      pkt(1'b0, 16'd0, 16'h0, 32'h0);
      chk("t4_ov3",    32'(bus_if.out_valid), 32'd1);
      chk("t4_ctr3",   32'(bus_if.out_ctr),   32'd3);
      chk("t4_data3",  bus_if.out_data,       32'h303);
      chk("t4_wheat4", 32'(bus_if.wheat_cnt), 32'd4);

      // 5: all consumed -> IDLE; output still drains; further packet ignored
      chk("t5_busy",  32'(bus_if.busy),     32'd0);
      chk("t5_ready", 32'(bus_if.in_ready), 32'd0);
      tick();
      chk("t5_drain", 32'(bus_if.out_valid), 32'd0);
      pkt(1'b1, 16'd2, 16'h00C2, 32'h502); tick();
      pkt(1'b0, 16'd0, 16'h0, 32'h0);
      chk("t5_idle_ov",    32'(bus_if.out_valid), 32'd0);
      chk("t5_idle_chaff", 32'(bus_if.chaff_cnt), 32'd4);
      chk("t5_idle_wheat", 32'(bus_if.wheat_cnt), 32'd4);

      // 6a: start mid-RUN with out_valid=1 and a packet offered in the same cycle
      bus_if.start = 1'b1; tick(); bus_if.start = 1'b0;
      load(1'b1, 16'h1110); tick();
      load(1'b1, 16'h1111); tick();
      load(1'b1, 16'h1112); tick();
      load(1'b1, 16'h1113); tick();
      load(1'b0, 16'h0);
      chk("t6_run_ready", 32'(bus_if.in_ready), 32'd1);
      bus_if.out_ready = 1'b0;
      pkt(1'b1, 16'd0, 16'h1110, 32'h600); tick();
      chk("t6_ov_set", 32'(bus_if.out_valid), 32'd1);
      bus_if.start = 1'b1;
      pkt(1'b1, 16'd1, 16'h1111, 32'h601); tick();
      bus_if.start = 1'b0;
      pkt(1'b0, 16'd0, 16'h0, 32'h0);
      chk("t6_start_ov",    32'(bus_if.out_valid),  32'd0);
      chk("t6_start_wheat", 32'(bus_if.wheat_cnt),  32'd0);
      chk("t6_start_chaff", 32'(bus_if.chaff_cnt),  32'd0);
      chk("t6_start_load",  32'(bus_if.load_ready), 32'd1);

      // 6b: async reset mid-LOAD, then a full reload must take exactly 4 writes
      load(1'b1, 16'h2220); tick();
      load(1'b1, 16'h2221); tick();
      load(1'b0, 16'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_arst_load", 32'(bus_if.load_ready), 32'd0);
      chk("t6_arst_busy", 32'(bus_if.busy),       32'd0);
      chk("t6_arst_ov",   32'(bus_if.out_valid),  32'd0);
      chk("t6_arst_wheat", 32'(bus_if.wheat_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      bus_if.start = 1'b1; tick(); bus_if.start = 1'b0;
      load(1'b1, 16'h3330); tick();
      load(1'b1, 16'h3331); tick();
      load(1'b1, 16'h3332); tick();
      load(1'b0, 16'h0);
      chk("t6_reload_3", 32'(bus_if.load_ready), 32'd1);
      load(1'b1, 16'h3333); tick();
      load(1'b0, 16'h0);
      chk("t6_reload_4", 32'(bus_if.load_ready), 32'd0);
      bus_if.out_ready = 1'b1;
      pkt(1'b1, 16'd3, 16'h3333, 32'h633); tick();
      pkt(1'b0, 16'd0, 16'h0, 32'h0);
      chk("t6_fwd_ctr",   32'(bus_if.out_ctr),   32'd3);
      chk("t6_fwd_wheat", 32'(bus_if.wheat_cnt), 32'd1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
